// File: rtl/spec_ram_pkg.sv
// Shared definitions for the spectrum RAM arbiter.
// Holds the RAM geometry, the owner encoding, the {real,imag} word
// layout and the read-tag payload carried down the read-return pipe.
package spec_ram_pkg;

    localparam int unsigned ADDR_W   = 9;
    localparam int unsigned DATA_W   = 36;

    // Field slices of one spectrum word {real[17:0], imag[17:0]}
    localparam int unsigned REAL_MSB = 35;
    localparam int unsigned REAL_LSB = 18;
    localparam int unsigned IMAG_MSB = 17;
    localparam int unsigned IMAG_LSB = 0;

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_W    = 2'd1,
        OWN_P    = 2'd2,
        OWN_R    = 2'd3
    } owner_t;

    typedef struct packed {
        logic [REAL_MSB-REAL_LSB:0] re;
        logic [IMAG_MSB-IMAG_LSB:0] im;
    } spec_word_t;

    // who: 0 = CORDIC reader (P), 1 = IFFT reader (R)
    typedef struct packed {
        logic valid;
        logic who;
    } rd_tag_t;

endpackage

// File: rtl/spectrum_ram_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-deep shift register of {valid,who} read tags that
// lines up with the RAM read latency. Resets to all-invalid, so any
// read in flight at reset is dropped.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   valid_i, who_i     tag of the read issued this cycle
//   valid_o, who_o     tag whose data is on ram_dout this cycle
module rd_tag_pipe
    import spec_ram_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_i,
    input  logic who_i,
    output logic valid_o,
    output logic who_o
);

    localparam int unsigned TAG_W  = $bits(rd_tag_t);
    localparam int unsigned PIPE_W = TAG_W * DEPTH;

    rd_tag_t             tag_in;
    rd_tag_t             tag_out;
    logic [PIPE_W-1:0]   pipe_q;
    logic [PIPE_W-1:0]   pipe_d;

    assign tag_in = '{valid: valid_i, who: who_i};

    // Newest tag enters at the bottom, oldest leaves at the top
    if (DEPTH == 1) begin : g_single
        assign pipe_d = tag_in;
    end else begin : g_multi
        assign pipe_d = {pipe_q[PIPE_W-TAG_W-1:0], tag_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign tag_out = pipe_q[PIPE_W-1 -: TAG_W];
    assign valid_o = tag_out.valid;
    assign who_o   = tag_out.who;

endmodule

// File: rtl/spectrum_ram_arbiter.sv
// spectrum_ram_arbiter: shares one single-port 36x512 spectrum RAM among
// the FFT writer (W, preemptive priority) and two readers, CORDIC sweep (P)
// and IFFT result (R), which alternate with bursts bounded by MAX_BURST.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   w_req/w_addr/w_data/w_gnt         writer handshake
//   p_req/p_addr/p_gnt/p_rvalid/p_rdata  CORDIC reader handshake + return
//   r_req/r_addr/r_gnt/r_rvalid/r_rdata  IFFT reader handshake + return
//   ram_addr/ram_din/ram_we/ram_dout  RAM port
//   owner                             0 idle, 1 W, 2 P, 3 R
// Optional build macro ARB_STATS_EN adds stats_clr, p_stall_cnt, r_stall_cnt.
module spectrum_ram_arbiter
    import spec_ram_pkg::*;
#(
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              w_req,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              w_gnt,
    input  logic              p_req,
    input  logic [ADDR_W-1:0] p_addr,
    output logic              p_gnt,
    output logic              p_rvalid,
    output logic [DATA_W-1:0] p_rdata,
    input  logic              r_req,
    input  logic [ADDR_W-1:0] r_addr,
    output logic              r_gnt,
    output logic              r_rvalid,
    output logic [DATA_W-1:0] r_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [1:0]        owner
`ifdef ARB_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [15:0]       p_stall_cnt,
    output logic [15:0]       r_stall_cnt
`endif
);

    localparam int unsigned       BEAT_W    = 8;
    localparam logic [BEAT_W-1:0] BURST_LIM = BEAT_W'(MAX_BURST - 1);

    owner_t              owner_q, owner_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                last_rd_q, last_rd_d;   // 0: P, 1: R
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   p_rdata_q, r_rdata_q;
    logic                tag_valid, tag_who;

    // Next owner: W preempts, then current reader continues within its burst,
    // then the reader that did not go last, then idle.
    always_comb begin
        owner_d   = OWN_IDLE;
        beat_d    = '0;
        last_rd_d = last_rd_q;

        if (w_req) begin
            owner_d = OWN_W;
        end else if (owner_q == OWN_P && p_req && (beat_q < BURST_LIM || !r_req)) begin
            owner_d = OWN_P;
        end else if (owner_q == OWN_R && r_req && (beat_q < BURST_LIM || !p_req)) begin
            owner_d = OWN_R;
        end else if (p_req && r_req) begin
            owner_d = last_rd_q ? OWN_P : OWN_R;
        end else if (p_req) begin
            owner_d = OWN_P;
        end else if (r_req) begin
            owner_d = OWN_R;
        end

        // Beat count restarts on every owner change and saturates otherwise
        if (owner_d == owner_q) begin
            beat_d = (beat_q == '1) ? beat_q : beat_q + BEAT_W'(1);
        end

        if (owner_d == OWN_P) begin
            last_rd_d = 1'b0;
        end else if (owner_d == OWN_R) begin
            last_rd_d = 1'b1;
        end
    end

    assign w_gnt = w_req && (owner_q == OWN_W);
    assign p_gnt = p_req && (owner_q == OWN_P);
    assign r_gnt = r_req && (owner_q == OWN_R);

    // RAM address follows the granted requester, otherwise holds
    always_comb begin
        ram_addr = addr_q;
        if (w_gnt) begin
            ram_addr = w_addr;
        end else if (p_gnt) begin
            ram_addr = p_addr;
        end else if (r_gnt) begin
            ram_addr = r_addr;
        end
    end

    assign ram_din = w_data;
    assign ram_we  = w_gnt;
    assign owner   = 2'(owner_q);

    rd_tag_pipe #(
        .DEPTH (RD_LAT)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (p_gnt | r_gnt),
        .who_i   (r_gnt),
        .valid_o (tag_valid),
        .who_o   (tag_who)
    );

    // Read data is routed to the tagged reader and held between returns
    assign p_rvalid = tag_valid && !tag_who;
    assign r_rvalid = tag_valid &&  tag_who;
    assign p_rdata  = p_rvalid ? ram_dout : p_rdata_q;
    assign r_rdata  = r_rvalid ? ram_dout : r_rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q   <= OWN_IDLE;
            beat_q    <= '0;
            last_rd_q <= 1'b1;
            addr_q    <= '0;
            p_rdata_q <= '0;
            r_rdata_q <= '0;
        end else begin
            owner_q   <= owner_d;
            beat_q    <= beat_d;
            last_rd_q <= last_rd_d;
            addr_q    <= ram_addr;
            p_rdata_q <= p_rdata;
            r_rdata_q <= r_rdata;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] p_stall_q, r_stall_q;

    // Saturating counts of requested-but-not-granted cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_stall_q <= '0;
            r_stall_q <= '0;
        end else if (stats_clr) begin
            p_stall_q <= '0;
            r_stall_q <= '0;
        end else begin
            if (p_req && !p_gnt && p_stall_q != 16'hFFFF) begin
                p_stall_q <= p_stall_q + 16'd1;
            end
            if (r_req && !r_gnt && r_stall_q != 16'hFFFF) begin
                r_stall_q <= r_stall_q + 16'd1;
            end
        end
    end

    assign p_stall_cnt = p_stall_q;
    assign r_stall_cnt = r_stall_q;
`endif

endmodule

// File: tb/tb_spectrum_ram_arbiter.sv
`timescale 1ns/1ps
module tb_spectrum_ram_arbiter;
    import spec_ram_pkg::*;

    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned MAX_BURST = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              w_req, p_req, r_req;
    logic [ADDR_W-1:0] w_addr, p_addr, r_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_gnt, p_gnt, r_gnt, p_rvalid, r_rvalid, ram_we;
    logic [DATA_W-1:0] p_rdata, r_rdata, ram_din, ram_dout;
    logic [ADDR_W-1:0] ram_addr;
    logic [1:0]        owner;
`ifdef ARB_STATS_EN
    logic              stats_clr;
    logic [15:0]       p_stall_cnt, r_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] ram_mem [512];
    logic [DATA_W-1:0] exp_mem [512];

    spectrum_ram_arbiter #(
        .RD_LAT    (RD_LAT),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .w_req    (w_req),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_gnt    (w_gnt),
        .p_req    (p_req),
        .p_addr   (p_addr),
        .p_gnt    (p_gnt),
        .p_rvalid (p_rvalid),
        .p_rdata  (p_rdata),
        .r_req    (r_req),
        .r_addr   (r_addr),
        .r_gnt    (r_gnt),
        .r_rvalid (r_rvalid),
        .r_rdata  (r_rdata),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout),
        .owner    (owner)
`ifdef ARB_STATS_EN
        ,
        .stats_clr   (stats_clr),
        .p_stall_cnt (p_stall_cnt),
        .r_stall_cnt (r_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Single-port RAM, one-cycle read latency
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_dout <= ram_mem[ram_addr];
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [DATA_W-1:0] pattern(input int i);
        return {18'(i * 5 + 3), 18'(i ^ 'h2A5A5)};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        w_req = 1'b0; p_req = 1'b0; r_req = 1'b0;
        w_addr = '0; p_addr = '0; r_addr = '0; w_data = '0;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (owner !== 2'd0) begin
            errors++; $display("FAIL reset_owner got %0d exp 0", owner);
        end
        checks++;
        if ({w_gnt, p_gnt, r_gnt, p_rvalid, r_rvalid, ram_we} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000", {w_gnt, p_gnt, r_gnt, p_rvalid, r_rvalid, ram_we});
        end
        checks++;
        if (p_rdata !== '0 || r_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata got %h %h exp 0 0", p_rdata, r_rdata);
        end
    endtask

    task automatic test_lone_p_burst();
        do_reset();
        p_req = 1'b1; p_addr = '0;
        @(negedge clk);
        checks++;
        if (p_gnt !== 1'b0) begin
            errors++; $display("FAIL burst_first_cycle p_gnt got %b exp 0", p_gnt);
        end
        for (int k = 0; k < 512; k++) begin
            @(posedge clk); #1;
            p_addr = ADDR_W'(k);
            @(negedge clk);
            checks++;
            if (p_gnt !== 1'b1 || ram_addr !== ADDR_W'(k) || owner !== 2'd2) begin
                errors++; $display("FAIL burst_gnt k=%0d got gnt=%b addr=%0d own=%0d exp 1 %0d 2", k, p_gnt, ram_addr, owner, k);
            end
            checks++;
            if (p_rvalid !== (k > 0) || (k > 0 && p_rdata !== pattern(k - 1))) begin
                errors++; $display("FAIL burst_rdata k=%0d got v=%b d=%h exp v=%b d=%h", k, p_rvalid, p_rdata, k > 0, pattern(k - 1));
            end
        end
        @(posedge clk); #1 p_req = 1'b0;
        @(negedge clk);
        checks++;
        if (p_gnt !== 1'b0 || p_rvalid !== 1'b1 || p_rdata !== pattern(511)) begin
            errors++; $display("FAIL burst_tail got gnt=%b v=%b d=%h exp 0 1 %h", p_gnt, p_rvalid, p_rdata, pattern(511));
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b0 || p_rdata !== pattern(511) || owner !== 2'd0) begin
            errors++; $display("FAIL burst_hold got v=%b d=%h own=%0d exp 0 %h 0", p_rvalid, p_rdata, owner, pattern(511));
        end
    endtask

    task automatic test_round_robin();
        logic exp_p, prev_p;
        prev_p = 1'b0;
        do_reset();
        p_req = 1'b1; r_req = 1'b1; p_addr = 9'd10; r_addr = 9'd20;
        @(negedge clk);
        checks++;
        if (p_gnt !== 1'b0 || r_gnt !== 1'b0) begin
            errors++; $display("FAIL rr_first_cycle got %b%b exp 00", p_gnt, r_gnt);
        end
        for (int j = 0; j < 64; j++) begin
            @(posedge clk); #1;
            @(negedge clk);
            exp_p = ((j / 16) % 2) == 0;
            checks++;
            if (p_gnt !== exp_p || r_gnt !== !exp_p || owner !== (exp_p ? 2'd2 : 2'd3)
                || ram_addr !== (exp_p ? 9'd10 : 9'd20)) begin
                errors++; $display("FAIL rr_owner j=%0d got p=%b r=%b own=%0d addr=%0d exp p=%b", j, p_gnt, r_gnt, owner, ram_addr, exp_p);
            end
            checks++;
            if (j > 0 && (p_rvalid !== prev_p || r_rvalid !== !prev_p)) begin
                errors++; $display("FAIL rr_rvalid j=%0d got p=%b r=%b exp p=%b", j, p_rvalid, r_rvalid, prev_p);
            end
            prev_p = exp_p;
        end
        @(posedge clk); #1 p_req = 1'b0; r_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_preempt();
        do_reset();
        p_req = 1'b1; p_addr = 9'd100;
        @(negedge clk);
        for (int b = 0; b < 6; b++) begin
            @(posedge clk); #1;
            p_addr = ADDR_W'(100 + b);
            if (b == 5) begin
                w_req = 1'b1; w_addr = 9'd7; w_data = 36'h123456789;
            end
            @(negedge clk);
            checks++;
            if (p_gnt !== 1'b1 || ram_addr !== ADDR_W'(100 + b) || w_gnt !== 1'b0) begin
                errors++; $display("FAIL preempt_beat b=%0d got p=%b w=%b addr=%0d exp 1 0 %0d", b, p_gnt, w_gnt, ram_addr, 100 + b);
            end
        end
        @(posedge clk); #1 p_addr = 9'd106;
        @(negedge clk);
        checks++;
        if (w_gnt !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 9'd7 || ram_din !== 36'h123456789
            || p_gnt !== 1'b0 || owner !== 2'd1) begin
            errors++; $display("FAIL preempt_write got w=%b we=%b addr=%0d din=%h p=%b own=%0d exp 1 1 7 123456789 0 1",
                               w_gnt, ram_we, ram_addr, ram_din, p_gnt, owner);
        end
        checks++;
        if (p_rvalid !== 1'b1 || p_rdata !== pattern(105)) begin
            errors++; $display("FAIL preempt_inflight got v=%b d=%h exp 1 %h", p_rvalid, p_rdata, pattern(105));
        end
        @(posedge clk); #1 w_req = 1'b0;
        @(negedge clk);
        checks++;
        if (w_gnt !== 1'b0 || ram_we !== 1'b0 || p_gnt !== 1'b0 || ram_addr !== 9'd7 || p_rvalid !== 1'b0) begin
            errors++; $display("FAIL preempt_release got w=%b we=%b p=%b addr=%0d v=%b exp 0 0 0 7 0", w_gnt, ram_we, p_gnt, ram_addr, p_rvalid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (p_gnt !== 1'b1 || owner !== 2'd2 || ram_addr !== 9'd106) begin
            errors++; $display("FAIL preempt_resume got p=%b own=%0d addr=%0d exp 1 2 106", p_gnt, owner, ram_addr);
        end
        @(posedge clk); #1 p_req = 1'b0;
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b1 || p_rdata !== pattern(106) || ram_mem[7] !== 36'h123456789) begin
            errors++; $display("FAIL preempt_after got v=%b d=%h mem7=%h exp 1 %h 123456789", p_rvalid, p_rdata, ram_mem[7], pattern(106));
        end
        exp_mem[7] = 36'h123456789;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_inflight();
        do_reset();
        p_req = 1'b1; p_addr = 9'd3;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (p_gnt !== 1'b1) begin
            errors++; $display("FAIL rst_inflight_gnt got %b exp 1", p_gnt);
        end
        @(posedge clk); #1 rst_n = 1'b0; p_req = 1'b0;
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL rst_inflight_drop got v=%b own=%0d exp 0 0", p_rvalid, owner);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (p_rvalid !== 1'b0 || r_rvalid !== 1'b0 || owner !== 2'd0) begin
            errors++; $display("FAIL rst_inflight_after got v=%b%b own=%0d exp 00 0", p_rvalid, r_rvalid, owner);
        end
        @(posedge clk); #1 p_req = 1'b1; r_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (owner !== 2'd2 || p_gnt !== 1'b1 || r_gnt !== 1'b0) begin
            errors++; $display("FAIL rst_tie got own=%0d p=%b r=%b exp 2 1 0", owner, p_gnt, r_gnt);
        end
        @(posedge clk); #1 p_req = 1'b0; r_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random();
        logic              lw, lp, lr, pend_p, pend_r;
        logic [DATA_W-1:0] pend_pd, pend_rd;
        int                p_wait, r_wait;
        lw = 1'b0; lp = 1'b0; lr = 1'b0; pend_p = 1'b0; pend_r = 1'b0;
        pend_pd = '0; pend_rd = '0; p_wait = 0; r_wait = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            if (!w_req || lw) begin
                w_req  = ($urandom_range(0, 9) == 0);
                w_addr = ADDR_W'($urandom_range(0, 511));
                w_data = DATA_W'({$urandom(), $urandom()});
            end
            if (!p_req || lp) begin
                p_req  = ($urandom_range(0, 3) != 0);
                p_addr = ADDR_W'($urandom_range(0, 511));
            end
            if (!r_req || lr) begin
                r_req  = ($urandom_range(0, 3) != 0);
                r_addr = ADDR_W'($urandom_range(0, 511));
            end
            @(negedge clk);
            checks++;
            if ($countones({w_gnt, p_gnt, r_gnt}) > 1) begin
                errors++; $display("FAIL rnd_onehot c=%0d got %b%b%b", c, w_gnt, p_gnt, r_gnt);
            end
            checks++;
            if ((w_gnt && !w_req) || (p_gnt && !p_req) || (r_gnt && !r_req)) begin
                errors++; $display("FAIL rnd_gnt_noreq c=%0d gnt %b%b%b req %b%b%b", c, w_gnt, p_gnt, r_gnt, w_req, p_req, r_req);
            end
            checks++;
            if ((w_gnt && (ram_addr !== w_addr || ram_din !== w_data || ram_we !== 1'b1))
                || (p_gnt && ram_addr !== p_addr) || (r_gnt && ram_addr !== r_addr) || (!w_gnt && ram_we !== 1'b0)) begin
                errors++; $display("FAIL rnd_port c=%0d got addr=%0d we=%b", c, ram_addr, ram_we);
            end
            checks++;
            if (p_rvalid !== pend_p || r_rvalid !== pend_r
                || (pend_p && p_rdata !== pend_pd) || (pend_r && r_rdata !== pend_rd)) begin
                errors++; $display("FAIL rnd_return c=%0d got v=%b%b d=%h %h exp v=%b%b d=%h %h",
                                   c, p_rvalid, r_rvalid, p_rdata, r_rdata, pend_p, pend_r, pend_pd, pend_rd);
            end
            pend_p  = p_gnt;
            pend_r  = r_gnt;
            pend_pd = exp_mem[p_addr];
            pend_rd = exp_mem[r_addr];
            if (w_gnt) exp_mem[w_addr] = w_data;
            p_wait = (p_req && !p_gnt && !w_req) ? p_wait + 1 : 0;
            r_wait = (r_req && !r_gnt && !w_req) ? r_wait + 1 : 0;
            checks++;
            if (p_wait > int'(MAX_BURST) + 1 || r_wait > int'(MAX_BURST) + 1) begin
                errors++; $display("FAIL rnd_starve c=%0d got wait p=%0d r=%0d max %0d", c, p_wait, r_wait, MAX_BURST + 1);
            end
            lw = w_gnt; lp = p_gnt; lr = r_gnt;
            @(posedge clk); #1;
        end
        w_req = 1'b0; p_req = 1'b0; r_req = 1'b0;
        @(negedge clk);
        checks++;
        if (p_rvalid !== pend_p || r_rvalid !== pend_r) begin
            errors++; $display("FAIL rnd_drain got v=%b%b exp %b%b", p_rvalid, r_rvalid, pend_p, pend_r);
        end
        repeat (2) @(posedge clk);
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        w_req = 1'b1; w_addr = 9'd1; w_data = '0; r_req = 1'b1; r_addr = 9'd5;
        repeat (40) @(posedge clk);
        #1 r_req = 1'b0;
        @(negedge clk);
        checks++;
        if (r_stall_cnt !== 16'd40 || p_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_count got r=%0d p=%0d exp 40 0", r_stall_cnt, p_stall_cnt);
        end
        @(posedge clk); #1 stats_clr = 1'b1;
        @(posedge clk); #1 stats_clr = 1'b0;
        @(negedge clk);
        checks++;
        if (r_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_clr got %0d exp 0", r_stall_cnt);
        end
        r_req = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (r_stall_cnt !== 16'hFFFF || p_stall_cnt !== 16'd0) begin
            errors++; $display("FAIL stats_sat got r=%h p=%h exp ffff 0", r_stall_cnt, p_stall_cnt);
        end
        @(posedge clk); #1 w_req = 1'b0; r_req = 1'b0;
        repeat (2) @(posedge clk);
    endtask
`endif

    initial begin
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] <= pattern(i);
            exp_mem[i] = pattern(i);
        end
        test_reset();
        test_lone_p_burst();
        test_round_robin();
        test_preempt();
        test_reset_inflight();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
